// File: rtl/board_reset_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_reset_sync_pkg
//  Description : Shared constants for the board reset / input front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_reset_sync_pkg;

  // Depth of the core-reset release synchroniser (assert async, release sync).
  localparam int RST_SYNC_STAGES = 2;

endpackage : board_reset_sync_pkg
`default_nettype wire

// File: rtl/board_reset_sync_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_filter
//  Description : One asynchronous input channel: N-stage synchroniser,
//                optional persistence filter and a delayed copy for edge
//                detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic IDLE_VALUE    = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic sync_q
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;
  logic                   sync_d;

  // Shift the raw pin into the synchroniser chain; oldest sample at the MSB.
  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], async_in};
    sync_d  = sync_out;
  end

  // Synchroniser chain and the one-cycle-delayed copy of the filtered level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= {SYNC_STAGES{IDLE_VALUE}};
      sync_q  <= IDLE_VALUE;
    end else begin
      stage_q <= stage_d;
      sync_q  <= sync_d;
    end
  end

  if (FILTER_CYCLES == 0) begin : g_bypass
    assign sync_out = stage_q[SYNC_STAGES-1];
  end else begin : g_filter
    localparam int            CW         = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] fcnt_q;
    logic [CW-1:0] fcnt_d;
    logic          level_q;
    logic          level_d;

    // Accept a new level only after it has differed for FILTER_CYCLES samples.
    always_comb begin
      fcnt_d  = fcnt_q;
      level_d = level_q;
      if (stage_q[SYNC_STAGES-1] == level_q) begin
        fcnt_d = '0;
      end else if (fcnt_q == LAST_COUNT) begin
        level_d = ~level_q;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + CW'(1);
      end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        fcnt_q  <= '0;
        level_q <= IDLE_VALUE;
      end else begin
        fcnt_q  <= fcnt_d;
        level_q <= level_d;
      end
    end

    assign sync_out = level_q;
  end

endmodule : sync_filter
`default_nettype wire

// File: rtl/board_reset_sync.sv
`default_nettype none
// ============================================================================
//  Module      : board_reset_sync
//  Description : Board front end: counted, synchronously released core reset
//                plus per-channel synchronised / filtered / edge-detected
//                asynchronous inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_reset_sync
  import board_reset_sync_pkg::*;
#(
  parameter int                  CHANNELS      = 1,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  HOLD_CYCLES   = 63,
  parameter int                  FILTER_CYCLES = 0,
  parameter logic [CHANNELS-1:0] IDLE_VALUE    = '1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                soft_reset,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                core_reset,
  output logic                ready
);

  localparam int             HCW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(HOLD_CYCLES);

  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  logic [RST_SYNC_STAGES-1:0] rst_sync_d;
  logic                       rst_ok;
  logic [HCW-1:0]             hold_cnt_q;
  logic [HCW-1:0]             hold_cnt_d;
  logic                       ready_q;
  logic                       ready_d;
  logic [CHANNELS-1:0]        sync_q;

  assign rst_ok = rst_sync_q[RST_SYNC_STAGES-1];

  // Hold sequence: count up once reset release has synchronised, restart on soft_reset.
  always_comb begin
    rst_sync_d = {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    hold_cnt_d = hold_cnt_q;
    ready_d    = ready_q | (hold_cnt_q == HOLD_MAX);
    if (soft_reset) begin
      hold_cnt_d = '0;
      ready_d    = 1'b0;
    end else if (rst_ok && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HCW'(1);
    end
  end

  // Reset synchroniser, hold counter and ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      hold_cnt_q <= hold_cnt_d;
      ready_q    <= ready_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .IDLE_VALUE   (IDLE_VALUE[i])
    ) u_sync_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .async_in(async_in[i]),
      .sync_out(sync_out[i]),
      .sync_q  (sync_q[i])
    );
  end

  // Edges are suppressed until the core is out of reset.
  assign rise       = sync_out & ~sync_q & {CHANNELS{ready_q}};
  assign fall       = ~sync_out & sync_q & {CHANNELS{ready_q}};
  assign ready      = ready_q;
  assign core_reset = ~ready_q;

endmodule : board_reset_sync
`default_nettype wire
